// File: rtl/galois_lfsr_pkg.sv
// Shared types and default parameters for the Galois LFSR checker and generator.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package galois_lfsr_pkg;

  localparam int DEF_N        = 48;
  localparam int DEF_CW       = 16;
  localparam int DEF_LOCK_CNT = 8;
  localparam int DEF_LOSS_CNT = 4;

  // Checker sync state; the 2-bit encoding is visible on debug taps.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACQ    = 2'd1,
    ST_LOCKED = 2'd2,
    ST_LOST   = 2'd3
  } state_t;

endpackage

// File: rtl/galois_lfsr_step.sv
// One Galois LFSR step: next state and the keystream bit of the current state.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the result.
module galois_lfsr_step #(
  parameter int N = 48
) (
  input  logic [N-1:0] cur,
  input  logic [N-1:0] taps,
  output logic [N-1:0] nxt,
  output logic         out_bit
);

  // Shift right and fold the feedback mask in when the outgoing bit is 1.
  always_comb begin
    out_bit = cur[0];
    nxt     = cur[0] ? ((cur >> 1) ^ taps) : (cur >> 1);
  end

endmodule

// File: rtl/galois_lfsr_checker.sv
// Galois LFSR keystream checker: acquires lock on a received bit stream, counts bits/errors.
// Latency: err, locked, lost and counters reflect a sampled en bit one cycle later.
// Backpressure: none; every en=1 cycle is consumed (stalls only in IDLE/LOST, where en is ignored).
module galois_lfsr_checker
  import galois_lfsr_pkg::*;
#(
  parameter int N        = DEF_N,
  parameter int CW       = DEF_CW,
  parameter int LOCK_CNT = DEF_LOCK_CNT,
  parameter int LOSS_CNT = DEF_LOSS_CNT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [N-1:0]  seed,
  input  logic [N-1:0]  taps,
  input  logic          en,
  input  logic          din,
  output logic          locked,
  output logic          lost,
  output logic          err,
  output logic [CW-1:0] err_cnt,
  output logic [CW-1:0] bit_cnt,
  output logic [N-1:0]  lfsr_o
);

  // Run counters only need to reach the threshold minus one before the transition fires.
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(LOSS_CNT + 1);
  localparam logic [GW-1:0] LOCK_LAST = GW'(LOCK_CNT - 1);
  localparam logic [BW-1:0] LOSS_LAST = BW'(LOSS_CNT - 1);

  state_t        state_q, state_d;
  logic [N-1:0]  lfsr_q, lfsr_d;
  logic [GW-1:0] good_q, good_d;
  logic [BW-1:0] bad_q, bad_d;
  logic [CW-1:0] err_cnt_q, err_cnt_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic          err_q, err_d;

  logic [N-1:0]  step_nxt;
  logic          exp_bit;
  logic          mismatch;

  galois_lfsr_step #(.N(N)) u_step (
    .cur     (lfsr_q),
    .taps    (taps),
    .nxt     (step_nxt),
    .out_bit (exp_bit)
  );

  assign mismatch = en & (din != exp_bit);

  // Register all checker state; reset forces the idle, all-zero condition immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      lfsr_q    <= '0;
      good_q    <= '0;
      bad_q     <= '0;
      err_cnt_q <= '0;
      bit_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      good_q    <= good_d;
      bad_q     <= bad_d;
      err_cnt_q <= err_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      err_q     <= err_d;
    end
  end

  // Next-state logic: start overrides everything; LFSR steps on every en bit in ACQ/LOCKED.
  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    good_d    = good_q;
    bad_d     = bad_q;
    err_cnt_d = err_cnt_q;
    bit_cnt_d = bit_cnt_q;
    err_d     = 1'b0;

    if (start) begin
      // The en/din presented alongside start belong to the old stream and are dropped.
      state_d   = ST_ACQ;
      lfsr_d    = seed;
      good_d    = '0;
      bad_d     = '0;
      err_cnt_d = '0;
      bit_cnt_d = '0;
    end else begin
      unique case (state_q)
        ST_ACQ: begin
          if (en) begin
            lfsr_d = step_nxt;
            if (mismatch) begin
              good_d = '0;
              err_d  = 1'b1;
            end else if (good_q == LOCK_LAST) begin
              good_d  = '0;
              state_d = ST_LOCKED;
            end else begin
              good_d = good_q + 1'b1;
            end
          end
        end
        ST_LOCKED: begin
          if (en) begin
            lfsr_d = step_nxt;
            if (bit_cnt_q != '1) bit_cnt_d = bit_cnt_q + 1'b1;
            if (mismatch) begin
              err_d = 1'b1;
              if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
              if (bad_q == LOSS_LAST) begin
                bad_d   = '0;
                state_d = ST_LOST;
              end else begin
                bad_d = bad_q + 1'b1;
              end
            end else begin
              bad_d = '0;
            end
          end
        end
        // IDLE and LOST freeze everything until the next start.
        default: begin
        end
      endcase
    end
  end

  assign locked  = (state_q == ST_LOCKED);
  assign lost    = (state_q == ST_LOST);
  assign err     = err_q;
  assign err_cnt = err_cnt_q;
  assign bit_cnt = bit_cnt_q;
  assign lfsr_o  = lfsr_q;

endmodule
